morse_keyer: RTL and testbench
==============================

Name: morse_keyer

Overview:
- Downstream consumer of the free-running 28-bit time-base counter in the Morse transmitter.
- Derives a Morse "unit" tick from one tap bit of the counter value.
- Accepts one encoded character at a time over a valid/ready handshake.
- Drives the KEY output with standard Morse timing:
  - dot = 1 unit, dash = 3 units
  - intra-character gap = 1 unit, inter-character gap = 3 units
  - word space = 7 units

Parameters:
TAP_BIT, 22, index of the counter bit whose 0->1 transition defines one unit tick. The default gives ≈84 ms at 100 MHz. Legal range 0..27.
MAX_LEN, 5, maximum symbols per character. LEN values above this are clamped to MAX_LEN.

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  reset, asynchronous, active-low (0 = reset)
CNT  input  28  free-running counter value from the time-base counter
CHAR_VALID  input  1  character descriptor valid
CHAR_READY  output  1  block can accept a descriptor this cycle
CHAR_LEN  input  3  number of symbols, 0..5
CHAR_PAT  input  5  symbol pattern; bit i is 1 for a dash, 0 for a dot; sent from bit 0 upward
CHAR_SPACE  input  1  1 = word space (7 units off), and CHAR_LEN/CHAR_PAT are ignored
KEY  output  1  keying output, 1 = tone on, registered
BUSY  output  1  high from acceptance until DONE, registered
DONE  output  1  one-cycle pulse when the character or space, including its trailing gap, completes

Behaviour:
- Reset (RST=0, asynchronous):
  - State is IDLE.
  - KEY=0, BUSY=0, DONE=0, CHAR_READY=1.
  - tap_prev=0, unit counter=0, symbol index=0.
- Tick generation:
  - tick = CNT[TAP_BIT] & ~tap_prev.
  - tap_prev is registered every cycle.
  - A tick is a one-cycle strobe. The first tick after reset is allowed if the tap bit is already 1.
- Handshake:
  - CHAR_READY=1 only in IDLE.
  - Transfer happens when CHAR_VALID & CHAR_READY are both high on a rising edge.
  - On transfer, LEN, PAT and SPACE are latched, and BUSY=1 and CHAR_READY=0 from the next cycle.
  - CHAR_VALID is ignored while not ready.
- Normalisation at capture:
  - LEN > MAX_LEN is clamped to MAX_LEN.
  - LEN == 0 with SPACE == 0 is treated as a word space.
- States: IDLE, ALIGN, MARK, GAP, CGAP, WSPACE. All timed transitions happen only on tick cycles; the new KEY value appears the cycle after that tick.
  - IDLE -> ALIGN on transfer.
  - ALIGN waits for the next tick, then goes to MARK (KEY=1) for a character or WSPACE for a space. This removes partial first units.
  - MARK loads the unit counter with 1 for a dot or 3 for a dash. It decrements on each tick and exits on the tick where the counter equals 1.
    - If more symbols remain, go to GAP (KEY=0, 1 unit).
    - After the last symbol, go to CGAP (KEY=0, 3 units).
  - GAP -> MARK after 1 tick, and the symbol index increments.
  - CGAP -> IDLE after 3 ticks. WSPACE -> IDLE after 7 ticks.
  - On entering IDLE, DONE=1 for exactly one cycle, BUSY=0 and CHAR_READY=1 in that same cycle.
- Back-to-back characters:
  - A new transfer is possible in the DONE cycle.
  - Two consecutive characters are separated by exactly 3 units of KEY=0 (CGAP), plus the ALIGN wait.
- KEY is never 1 outside MARK.
- Unit counter is 3 bits wide, with no wrap: it is only decremented while nonzero.
- CNT wrap-around (all ones -> 0) needs no special handling; tick stays edge-based.
- Reset asserted mid-character: KEY drops to 0 immediately (asynchronous), and no DONE pulse is generated.
- A CNT tap bit that stops toggling stalls the block in its current state with outputs held; this is not an error.

Test Plan:
- Bench setup: TAP_BIT=2 (tick every 8 CLK), CNT driven by an incrementing counter.
- Reset: RST=0 mid-run -> KEY=0, BUSY=0, DONE=0, CHAR_READY=1 within the same cycle, with no clock required.
- "A" (LEN=2, PAT=b10, dot then dash) -> KEY high 8 cycles, low 8, high 24, then low 24. DONE pulses once, 8 cycles after the final tick-aligned edge of CGAP, i.e. on the 3rd CGAP tick. BUSY spans acceptance to DONE.
- Word space (SPACE=1) -> KEY stays 0, and DONE arrives exactly 7 ticks after the ALIGN tick.
- Clamping: LEN=7, PAT=b11111 -> exactly 5 dashes (each 24 cycles high). LEN=0, SPACE=0 -> behaves as a word space.
- Handshake: hold CHAR_VALID=1 with "E" (LEN=1, PAT=0) then "T" (LEN=1, PAT=1).
  - The second descriptor is accepted exactly in the DONE cycle.
  - KEY low exactly 3 units plus the ALIGN wait between the marks.
  - Descriptors offered while BUSY=1 are not consumed.
- Abort: assert RST during a dash -> KEY=0 immediately. After release, "E" sends normally with no spurious DONE from the aborted character.

Source files
------------

// File: rtl/morse_keyer.sv
// Morse keyer: turns one captured character descriptor into KEY on/off timing.
// One unit is the interval between rising edges of a chosen time-base counter bit.
module morse_keyer #(
  parameter int TAP_BIT = 22,
  parameter int MAX_LEN = 5
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [27:0] CNT,
  input  logic        CHAR_VALID,
  output logic        CHAR_READY,
  input  logic [2:0]  CHAR_LEN,
  input  logic [4:0]  CHAR_PAT,
  input  logic        CHAR_SPACE,
  output logic        KEY,
  output logic        BUSY,
  output logic        DONE
);

  localparam logic [2:0] MAX_L = 3'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN, S_MARK, S_GAP, S_CGAP, S_WSPACE
  } state_t;

  state_t     state, state_d;
  logic       tap_prev, tick, accept, last_sym;
  logic [2:0] unit_cnt, unit_d, sym_idx, idx_d, idx_nxt;
  logic [2:0] len_q, len_d;
  logic [4:0] pat_q, pat_d;
  logic       space_q, space_d;
  logic       key_d, busy_d, done_d;

  // Only the tap bit matters; the rest of the counter is deliberately ignored.
  logic unused_cnt;
  assign unused_cnt = ^CNT;

  function automatic logic [2:0] clamp_len(input logic [2:0] len);
    return (len > MAX_L) ? MAX_L : len;
  endfunction

  function automatic logic [2:0] sym_units(input logic dash);
    return dash ? 3'd3 : 3'd1;
  endfunction

  assign tick       = CNT[TAP_BIT] & ~tap_prev;
  assign CHAR_READY = (state == S_IDLE);
  assign accept     = CHAR_VALID & CHAR_READY;
  assign idx_nxt    = sym_idx + 3'd1;
  assign last_sym   = (idx_nxt >= len_q);

  always_comb begin
    state_d = state;
    unit_d  = unit_cnt;
    idx_d   = sym_idx;
    key_d   = KEY;
    busy_d  = BUSY;
    done_d  = 1'b0;
    len_d   = len_q;
    pat_d   = pat_q;
    space_d = space_q;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_d = S_ALIGN;
          busy_d  = 1'b1;
          len_d   = clamp_len(CHAR_LEN);
          pat_d   = CHAR_PAT;
          space_d = CHAR_SPACE | (CHAR_LEN == 3'd0);
          idx_d   = 3'd0;
          unit_d  = 3'd0;
        end
      end
      // Waiting for a whole unit boundary so the first unit is never short.
      S_ALIGN: begin
        if (tick) begin
          idx_d = 3'd0;
          if (space_q) begin
            state_d = S_WSPACE;
            unit_d  = 3'd7;
          end else begin
            state_d = S_MARK;
            key_d   = 1'b1;
            unit_d  = sym_units(pat_q[0]);
          end
        end
      end
      S_MARK: begin
        if (tick) begin
          if (unit_cnt == 3'd1) begin
            key_d = 1'b0;
            if (last_sym) begin
              state_d = S_CGAP;
              unit_d  = 3'd3;
            end else begin
              state_d = S_GAP;
              unit_d  = 3'd1;
            end
          end else if (unit_cnt != 3'd0) begin
            unit_d = unit_cnt - 3'd1;
          end
        end
      end
      S_GAP: begin
        if (tick) begin
          state_d = S_MARK;
          key_d   = 1'b1;
          idx_d   = idx_nxt;
          unit_d  = sym_units(pat_q[idx_nxt]);
        end
      end
      S_CGAP, S_WSPACE: begin
        if (tick) begin
          if (unit_cnt == 3'd1) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            unit_d  = 3'd0;
          end else if (unit_cnt != 3'd0) begin
            unit_d = unit_cnt - 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= S_IDLE;
      tap_prev <= 1'b0;
      unit_cnt <= 3'd0;
      sym_idx  <= 3'd0;
      KEY      <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      state    <= state_d;
      tap_prev <= CNT[TAP_BIT];
      unit_cnt <= unit_d;
      sym_idx  <= idx_d;
      KEY      <= key_d;
      BUSY     <= busy_d;
      DONE     <= done_d;
    end
  end

  // Captured descriptor is plain data and needs no reset.
  always_ff @(posedge CLK) begin
    len_q   <= len_d;
    pat_q   <= pat_d;
    space_q <= space_d;
  end

endmodule

// File: tb/tb_morse_keyer.sv
// Bench for morse_keyer: directed cases plus random characters against a unit-queue model.
module tb_morse_keyer;
  localparam int TAP = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic [27:0] CNT;
  logic        CHAR_VALID, CHAR_READY, CHAR_SPACE;
  logic [2:0]  CHAR_LEN;
  logic [4:0]  CHAR_PAT;
  logic        KEY, BUSY, DONE;

  int total = 0;
  int bad   = 0;

  // Model: a character is a list of unit levels consumed one per tick.
  bit m_busy, m_key, m_done, m_prev;
  bit unitq[$];
  bit acc_flag;

  int cyc, done_cnt, high_cyc, last_done_cyc;
  int rises[$];
  int falls[$];
  bit prev_key_s, prev_done_s, acc_in_done;

  always #5 CLK = ~CLK;

  morse_keyer #(.TAP_BIT(TAP), .MAX_LEN(5)) dut (
    .CLK(CLK), .RST(RST), .CNT(CNT),
    .CHAR_VALID(CHAR_VALID), .CHAR_READY(CHAR_READY),
    .CHAR_LEN(CHAR_LEN), .CHAR_PAT(CHAR_PAT), .CHAR_SPACE(CHAR_SPACE),
    .KEY(KEY), .BUSY(BUSY), .DONE(DONE)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void load_units(input logic [2:0] len, input logic [4:0] pat, input logic sp);
    int n;
    logic [4:0] p;
    unitq.delete();
    n = (len > 3'd5) ? 5 : int'(len);
    p = pat;
    if (sp || n == 0) begin
      for (int k = 0; k < 7; k++) unitq.push_back(1'b0);
    end else begin
      for (int i = 0; i < n; i++) begin
        for (int k = 0; k < (p[0] ? 3 : 1); k++) unitq.push_back(1'b1);
        if (i < n - 1) unitq.push_back(1'b0);
        p = p >> 1;
      end
      for (int k = 0; k < 3; k++) unitq.push_back(1'b0);
    end
  endfunction

  task automatic model_reset();
    m_busy = 0; m_key = 0; m_done = 0; m_prev = 0;
    unitq.delete();
  endtask

  task automatic clear_stats();
    done_cnt = 0; high_cyc = 0; last_done_cyc = 0; acc_in_done = 0;
    rises.delete(); falls.delete();
  endtask

  task automatic step();
    logic tk, was_idle, v, s;
    logic [2:0] l;
    logic [4:0] p;
    tk = CNT[TAP] & ~m_prev;
    was_idle = !m_busy;
    v = CHAR_VALID; l = CHAR_LEN; p = CHAR_PAT; s = CHAR_SPACE;
    @(posedge CLK);
    acc_flag = 0;
    m_done = 0;
    if (!RST) begin
      model_reset();
    end else begin
      m_prev = CNT[TAP];
      if (m_busy && tk) begin
        if (unitq.size() > 0) m_key = unitq.pop_front();
        else begin
          m_key = 0; m_busy = 0; m_done = 1;
        end
      end
      if (was_idle && v) begin
        load_units(l, p, s);
        m_busy = 1;
        acc_flag = 1;
      end
    end
    #1;
    cyc++;
    chk1("key", KEY, m_key);
    chk1("busy", BUSY, m_busy);
    chk1("done", DONE, m_done);
    chk1("ready", CHAR_READY, !m_busy);
    if (DONE) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (KEY) high_cyc++;
    if (KEY && !prev_key_s) rises.push_back(cyc);
    if (!KEY && prev_key_s) falls.push_back(cyc);
    if (BUSY && prev_done_s) acc_in_done = 1;
    prev_key_s = KEY;
    prev_done_s = DONE;
    CNT = CNT + 28'd1;
  endtask

  task automatic send(input logic [2:0] len, input logic [4:0] pat, input logic sp, input bit hold);
    int k;
    CHAR_LEN = len; CHAR_PAT = pat; CHAR_SPACE = sp; CHAR_VALID = 1'b1;
    k = 0;
    acc_flag = 0;
    while (!acc_flag && k < 400) begin
      step();
      k++;
    end
    chk1("accept_wait", acc_flag, 1'b1);
    if (!hold) CHAR_VALID = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int k;
    k = 0;
    while (m_busy && k < lim) begin
      step();
      k++;
    end
    chk1("idle_wait", m_busy, 1'b0);
  endtask

  task automatic check_reset_now(input string tag);
    #1;
    chk1({tag, "_key"}, KEY, 1'b0);
    chk1({tag, "_busy"}, BUSY, 1'b0);
    chk1({tag, "_done"}, DONE, 1'b0);
    chk1({tag, "_ready"}, CHAR_READY, 1'b1);
  endtask

  initial begin
    RST = 1'b0; CNT = 28'd3; CHAR_VALID = 1'b0;
    CHAR_LEN = 3'd0; CHAR_PAT = 5'd0; CHAR_SPACE = 1'b0;
    cyc = 0; prev_key_s = 0; prev_done_s = 0;
    model_reset();
    clear_stats();
    #1;
    check_reset_now("por");
    repeat (3) step();
    RST = 1'b1;
    repeat (5) step();

    // "A": dot then dash
    clear_stats();
    send(3'd2, 5'b00010, 1'b0, 0);
    wait_idle(400);
    repeat (4) step();
    chkn("A_high", high_cyc, 32);
    chkn("A_done_cnt", done_cnt, 1);
    chkn("A_marks", rises.size(), 2);
    if (rises.size() == 2 && falls.size() == 2) begin
      chkn("A_dot_len", falls[0] - rises[0], 8);
      chkn("A_gap_len", rises[1] - falls[0], 8);
      chkn("A_dash_len", falls[1] - rises[1], 24);
      chkn("A_cgap_len", last_done_cyc - falls[1], 24);
    end

    // word space, explicit and via LEN=0
    clear_stats();
    send(3'd3, 5'b10101, 1'b1, 0);
    wait_idle(400);
    send(3'd0, 5'b11111, 1'b0, 0);
    wait_idle(400);
    repeat (3) step();
    chkn("space_high", high_cyc, 0);
    chkn("space_done_cnt", done_cnt, 2);

    // clamp LEN=7 to five dashes
    clear_stats();
    send(3'd7, 5'b11111, 1'b0, 0);
    wait_idle(600);
    chkn("clamp_high", high_cyc, 120);
    chkn("clamp_marks", rises.size(), 5);

    // E then T with VALID held throughout
    clear_stats();
    repeat ($urandom_range(0, 7)) step();
    send(3'd1, 5'b00000, 1'b0, 1);
    CHAR_PAT = 5'b00001;
    send(3'd1, 5'b00001, 1'b0, 0);
    wait_idle(400);
    chk1("ET_acc_in_done", acc_in_done, 1'b1);
    chkn("ET_done_cnt", done_cnt, 2);
    chkn("ET_marks", rises.size(), 2);
    if (rises.size() == 2 && falls.size() == 2) begin
      chkn("ET_E_len", falls[0] - rises[0], 8);
      chkn("ET_low_between", rises[1] - falls[0], 32);
      chkn("ET_T_len", falls[1] - rises[1], 24);
    end

    // abort during a dash
    clear_stats();
    send(3'd2, 5'b00011, 1'b0, 0);
    begin
      int k;
      k = 0;
      while (!KEY && k < 100) begin
        step();
        k++;
      end
    end
    chk1("abort_key_on", KEY, 1'b1);
    repeat (5) step();
    #2;
    RST = 1'b0;
    check_reset_now("abort");
    model_reset();
    repeat (3) step();
    RST = 1'b1;
    clear_stats();
    repeat (3) step();
    send(3'd1, 5'b00000, 1'b0, 0);
    wait_idle(400);
    repeat (10) step();
    chkn("abort_E_done_cnt", done_cnt, 1);
    chkn("abort_E_high", high_cyc, 8);

    // random characters, sometimes offered while still busy
    clear_stats();
    for (int n = 0; n < 25; n++) begin
      logic [2:0] rl;
      logic [4:0] rp;
      logic rs;
      bit hold;
      rl = 3'($urandom_range(0, 7));
      rp = 5'($urandom);
      rs = ($urandom_range(0, 5) == 0);
      hold = ($urandom_range(0, 2) == 0);
      if (!hold) repeat ($urandom_range(0, 12)) step();
      send(rl, rp, rs, hold);
    end
    CHAR_VALID = 1'b0;
    wait_idle(400);
    repeat (3) step();
    chkn("rand_done_cnt", done_cnt, 25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
